layer_mem_arbiter: RTL and testbench
====================================

LAYER_MEM_ARBITER -- requirements
Module: layer_mem_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 12, layer-memory address width.
REQ-002 The module SHALL have parameter DATA_W, default 13, layer-memory data width.
REQ-003 The module SHALL have parameter MAX_LOCK, default 8, maximum consecutive locked grants.
REQ-004 The module SHALL have port clk, input, 1, clock; all state changes on the rising edge.
REQ-005 The module SHALL have port reset, input, 1, asynchronous, active-high.
REQ-006 For n in {0,1}, the module SHALL have port reqn, input, 1, access request, held until granted.
REQ-007 For n in {0,1}, the module SHALL have port wen, input, 1, 1 = write, 0 = read.
REQ-008 For n in {0,1}, the module SHALL have port seln, input, 1, memory select, driven to csel.
REQ-009 For n in {0,1}, the module SHALL have port addrn, input, ADDR_W, access address.
REQ-010 For n in {0,1}, the module SHALL have port wdatan, input, DATA_W, write data.
REQ-011 For n in {0,1}, the module SHALL have port lockn, input, 1, request to keep ownership for the next access.
REQ-012 For n in {0,1}, the module SHALL have port gntn, output, 1, combinational grant for the current cycle.
REQ-013 For n in {0,1}, the module SHALL have port rvalidn, output, 1, read data valid for requester n.
REQ-014 The module SHALL have port rdata, output, DATA_W, registered read data shared by both requesters.
REQ-015 The module SHALL have ports cwr/crd/csel, output, 1 each, registered memory strobes and select.
REQ-016 The module SHALL have ports caddr_wr/caddr_rd, output, ADDR_W, registered memory addresses.
REQ-017 The module SHALL have port cdata_wr, output, DATA_W, registered write data.
REQ-018 The module SHALL have port cdata_rd, input, DATA_W, memory read data, valid the cycle after crd.

Function
REQ-019 The arbiter SHALL use three states: IDLE, OWN0, OWN1; the state names the requester granted in the current cycle.
REQ-020 At most one gntn SHALL be high per cycle, and gntn SHALL be high only while reqn is high.
REQ-021 Grant selection per cycle:
- Owner k with lockk=1, reqk=1 and lock_cnt<MAX_LOCK keeps the grant.
- Otherwise, if only one requester is active, that requester is granted.
- If both are active, the requester other than last_owner is granted (round-robin).
REQ-022 On a grant edge, the arbiter SHALL register the granted fields into the memory outputs for exactly one cycle:
- write (we=1): cwr=1, caddr_wr=addr, cdata_wr=wdata.
- read (we=0): crd=1, caddr_rd=addr.
- In both cases: csel=sel.
REQ-023 With no grant, cwr and crd SHALL be 0; addresses, data and csel SHALL hold their last values.
REQ-024 Read latency: grant in cycle t, crd high in cycle t+1, and rvalidn high in cycle t+2 with rdata = cdata_rd sampled at the end of t+1.
REQ-025 A requester SHALL be grantable in consecutive cycles, giving one access per cycle with no bubble.
REQ-026 lock_cnt handling:
- lock_cnt SHALL increment on each locked re-grant to the same owner.
- lock_cnt SHALL clear on any owner change or on a grant with lock=0.
- At lock_cnt=MAX_LOCK, the lock SHALL be ignored for one arbitration.
REQ-027 last_owner SHALL update on every grant. With no requests the state SHALL return to IDLE and last_owner SHALL hold.
REQ-028 If a read and a write to the same address are granted back-to-back, memory order SHALL equal grant order; the arbiter performs no forwarding.

Reset
REQ-029 While reset is high, the following outputs SHALL be 0 immediately: gnt0/1, rvalid0/1, rdata, cwr, crd, csel, caddr_wr, caddr_rd, cdata_wr.
REQ-030 Reset SHALL set state=IDLE, lock_cnt=0 and last_owner=1, so requester 0 wins the first tie.
REQ-031 A reset asserted mid-read SHALL discard the pending rvalid; no rvalid SHALL appear after reset is released.

Structure
REQ-032 A shared package atconv_pkg SHALL hold ADDR_W, DATA_W, MAX_LOCK and the arbiter state enumeration (IDLE, OWN0, OWN1).
REQ-033 The block SHALL be a single module with no sub-module; grant logic is combinational and all memory-side outputs are registered.

Verification
REQ-034 Single write: req0=1, we0=1, sel0=0, addr0=12'd5, wdata0=13'd100 for one cycle -> gnt0 high that cycle; next cycle cwr=1, caddr_wr=5, cdata_wr=100, csel=0.
REQ-035 Read latency: req1=1, we1=0, sel1=1, addr1=12'd1023 granted at t; memory returns 13'd77 -> crd=1, csel=1 at t+1; rvalid1=1, rdata=77 at t+2.
REQ-036 Round-robin: req0 and req1 both held high for 4 cycles from reset -> grants alternate 0,1,0,1.
REQ-037 Lock limit: req0=lock0=1 and req1=1 held continuously -> gnt0 for 9 consecutive cycles (1 initial grant + MAX_LOCK=8 locked re-grants), then gnt1 for 1 cycle.
REQ-038 Reset mid-read: read granted at t, reset pulsed during t+1 -> cwr=crd=0 immediately; no rvalid0/1 at t+2 or after.

Source files
------------

// File: rtl/atconv_pkg.sv
// rtl/atconv_pkg.sv - shared sizes and arbiter state encoding for the layer-memory arbiter
package atconv_pkg;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 13;
  localparam int MAX_LOCK = 8;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t IDLE = 2'd0;
  localparam arb_state_t OWN0 = 2'd1;
  localparam arb_state_t OWN1 = 2'd2;

endpackage

// File: rtl/layer_mem_arbiter.sv
// rtl/layer_mem_arbiter.sv - two-requester layer-memory arbiter with lock and round-robin
// Combinational grant, registered memory strobes; read data returns two cycles after grant.
module layer_mem_arbiter
  import atconv_pkg::*;
#(
  parameter int ADDR_W   = atconv_pkg::ADDR_W,
  parameter int DATA_W   = atconv_pkg::DATA_W,
  parameter int MAX_LOCK = atconv_pkg::MAX_LOCK
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic              sel0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              lock0,
  input  logic              req1,
  input  logic              we1,
  input  logic              sel1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              cwr,
  output logic              crd,
  output logic              csel,
  output logic [ADDR_W-1:0] caddr_wr,
  output logic [ADDR_W-1:0] caddr_rd,
  output logic [DATA_W-1:0] cdata_wr,
  input  logic [DATA_W-1:0] cdata_rd
);

  localparam int LOCK_W = $clog2(MAX_LOCK + 1);
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(MAX_LOCK);

  arb_state_t        state;
  logic [LOCK_W-1:0] lock_cnt;
  logic              last_owner;
  logic [1:0]        rd_pend;

  logic              keep0, keep1, locked;
  logic              m_we, m_sel;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;

  // A locked owner keeps the bus until lock_cnt saturates; then fall through to round-robin.
  always_comb begin
    keep0 = (state == OWN0) && req0 && lock0 && (lock_cnt < LOCK_MAX);
    keep1 = (state == OWN1) && req1 && lock1 && (lock_cnt < LOCK_MAX);
    locked = keep0 || keep1;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (keep0)              gnt0 = 1'b1;
    else if (keep1)         gnt1 = 1'b1;
    else if (req0 && req1)  begin
      gnt0 = last_owner;
      gnt1 = ~last_owner;
    end
    else if (req0)          gnt0 = 1'b1;
    else if (req1)          gnt1 = 1'b1;
    if (reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  always_comb begin
    m_we    = gnt1 ? we1    : we0;
    m_sel   = gnt1 ? sel1   : sel0;
    m_addr  = gnt1 ? addr1  : addr0;
    m_wdata = gnt1 ? wdata1 : wdata0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lock_cnt   <= '0;
      last_owner <= 1'b1;
      rd_pend    <= 2'b00;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      rdata      <= '0;
      cwr        <= 1'b0;
      crd        <= 1'b0;
      csel       <= 1'b0;
      caddr_wr   <= '0;
      caddr_rd   <= '0;
      cdata_wr   <= '0;
    end else begin
      cwr     <= 1'b0;
      crd     <= 1'b0;
      rd_pend <= 2'b00;
      rvalid0 <= rd_pend[0];
      rvalid1 <= rd_pend[1];
      // cdata_rd is valid the cycle after crd, i.e. while rd_pend is set.
      if (|rd_pend) rdata <= cdata_rd;
      if (gnt0 || gnt1) begin
        state      <= gnt0 ? OWN0 : OWN1;
        last_owner <= gnt1;
        lock_cnt   <= locked ? lock_cnt + 1'b1 : '0;
        csel       <= m_sel;
        if (m_we) begin
          cwr      <= 1'b1;
          caddr_wr <= m_addr;
          cdata_wr <= m_wdata;
        end else begin
          crd      <= 1'b1;
          caddr_rd <= m_addr;
          rd_pend  <= {gnt1, gnt0};
        end
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_layer_mem_arbiter.sv
// tb/tb_layer_mem_arbiter.sv - directed vector bench for layer_mem_arbiter
module tb_layer_mem_arbiter;

  logic        clk, reset;
  logic        req0, we0, sel0, lock0, req1, we1, sel1, lock1;
  logic [11:0] addr0, addr1;
  logic [12:0] wdata0, wdata1, cdata_rd;
  logic        gnt0, gnt1, rvalid0, rvalid1, cwr, crd, csel;
  logic [12:0] rdata, cdata_wr;
  logic [11:0] caddr_wr, caddr_rd;

  int checks = 0;
  int errors = 0;

  layer_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .sel0(sel0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
    .req1(req1), .we1(we1), .sel1(sel1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .cwr(cwr), .crd(crd), .csel(csel), .caddr_wr(caddr_wr), .caddr_rd(caddr_rd),
    .cdata_wr(cdata_wr), .cdata_rd(cdata_rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        req0, req1, we0, we1, sel0, sel1;
    logic [11:0] addr0, addr1;
    logic [12:0] wdata0, wdata1, cdata_rd;
    logic [1:0]  egnt;
    logic        ecwr, ecrd, ecsel;
    logic [11:0] ewr, erd;
    logic [12:0] edata;
    logic [1:0]  erv;
    logic [12:0] erdata;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input int r0, r1, w0, w1, s0, s1, a0, a1, d0, d1, crdat,
                              eg, ecw, ecr, ecs, ewr, erd, edat, erv, erdat);
    vec_t v;
    v.req0 = r0[0]; v.req1 = r1[0]; v.we0 = w0[0]; v.we1 = w1[0];
    v.sel0 = s0[0]; v.sel1 = s1[0];
    v.addr0 = 12'(a0); v.addr1 = 12'(a1);
    v.wdata0 = 13'(d0); v.wdata1 = 13'(d1); v.cdata_rd = 13'(crdat);
    v.egnt = 2'(eg); v.ecwr = ecw[0]; v.ecrd = ecr[0]; v.ecsel = ecs[0];
    v.ewr = 12'(ewr); v.erd = 12'(erd); v.edata = 13'(edat);
    v.erv = 2'(erv); v.erdata = 13'(erdat);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mem_side();
    return 64'({cwr, crd, csel, caddr_wr, caddr_rd, cdata_wr, rvalid0, rvalid1, rdata});
  endfunction

  task automatic idle_inputs();
    req0 = 0; we0 = 0; sel0 = 0; lock0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; sel1 = 0; lock1 = 0; addr1 = '0; wdata1 = '0;
    cdata_rd = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    req0 = 1; we0 = 1; addr0 = 12'd9; wdata0 = 13'd9;
    @(posedge clk);
    #1;
    chk("reset_gnt", 64'({gnt0, gnt1}), 64'd0);
    chk("reset_outputs", mem_side(), 64'd0);

    vecs[0]  = mk(1,0, 1,0, 0,0, 5,0, 100,0, 0,    2, 1,0,0, 5,0,100,     0, 0);
    vecs[1]  = mk(0,1, 0,0, 0,1, 0,1023, 0,0, 0,   1, 0,1,1, 5,1023,100,  0, 0);
    vecs[2]  = mk(0,0, 0,0, 0,0, 0,0, 0,0, 77,     0, 0,0,1, 5,1023,100,  1, 77);
    vecs[3]  = mk(0,0, 0,0, 0,0, 0,0, 0,0, 0,      0, 0,0,1, 5,1023,100,  0, 77);
    vecs[4]  = mk(1,1, 1,0, 0,1, 7,9, 11,0, 0,     2, 1,0,0, 7,1023,11,   0, 77);
    vecs[5]  = mk(1,1, 1,0, 0,1, 7,9, 11,0, 0,     1, 0,1,1, 7,9,11,      0, 77);
    vecs[6]  = mk(1,1, 1,0, 0,1, 7,9, 11,0, 123,   2, 1,0,0, 7,9,11,      1, 123);
    vecs[7]  = mk(1,1, 1,0, 0,1, 7,9, 11,0, 0,     1, 0,1,1, 7,9,11,      0, 123);
    vecs[8]  = mk(0,0, 0,0, 0,0, 0,0, 0,0, 5,      0, 0,0,1, 7,9,11,      1, 5);
    vecs[9]  = mk(1,0, 1,0, 0,0, 1,0, 1,0, 0,      2, 1,0,0, 1,9,1,       0, 5);
    vecs[10] = mk(1,0, 1,0, 0,0, 2,0, 2,0, 0,      2, 1,0,0, 2,9,2,       0, 5);
    vecs[11] = mk(1,0, 0,0, 1,0, 2,0, 0,0, 0,      2, 0,1,1, 2,2,2,       0, 5);
    vecs[12] = mk(0,0, 0,0, 0,0, 0,0, 0,0, 2,      0, 0,0,1, 2,2,2,       2, 2);

    do_reset();
    for (int i = 0; i < 13; i++) begin
      req0 = vecs[i].req0; we0 = vecs[i].we0; sel0 = vecs[i].sel0;
      addr0 = vecs[i].addr0; wdata0 = vecs[i].wdata0;
      req1 = vecs[i].req1; we1 = vecs[i].we1; sel1 = vecs[i].sel1;
      addr1 = vecs[i].addr1; wdata1 = vecs[i].wdata1;
      cdata_rd = vecs[i].cdata_rd;
      #1;
      chk($sformatf("vec%0d_gnt", i), 64'({gnt0, gnt1}), 64'(vecs[i].egnt));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_mem", i), mem_side(),
          64'({vecs[i].ecwr, vecs[i].ecrd, vecs[i].ecsel, vecs[i].ewr, vecs[i].erd,
               vecs[i].edata, vecs[i].erv, vecs[i].erdata}));
    end

    // Lock limit: nine grants to 0, one to 1, then back to 0.
    do_reset();
    req0 = 1; lock0 = 1; we0 = 1; req1 = 1; we1 = 1;
    for (int c = 0; c < 11; c++) begin
      #1;
      chk($sformatf("lock_c%0d_gnt", c), 64'({gnt0, gnt1}), (c == 9) ? 64'd1 : 64'd2);
      @(posedge clk);
      #1;
    end

    // Reset in the middle of a read must drop the pending rvalid.
    do_reset();
    req0 = 1; we0 = 0; sel0 = 1; addr0 = 12'd3;
    #1;
    chk("midrd_gnt", 64'({gnt0, gnt1}), 64'd2);
    @(posedge clk);
    #1;
    idle_inputs();
    cdata_rd = 13'd55;
    chk("midrd_crd", 64'({cwr, crd}), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrd_async_clear", 64'({cwr, crd, rvalid0, rvalid1}), 64'd0);
    #1 reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("midrd_norvalid%0d", c), 64'({rvalid0, rvalid1}), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
